// File: rtl/ext_bus_arbiter_pkg.sv
// ext_bus_arbiter_pkg: shared types and constants for the external bus arbiter
// Contents: arbiter state type, requester indices, default geometry.
package ext_bus_arbiter_pkg;
    typedef enum logic {ARB_IDLE, ARB_BURST} arb_state_t;
    localparam int REQ_KERNEL = 0;
    localparam int REQ_INPUT = 1;
    localparam int REQ_OUTPUT = 2;
    localparam int ARB_NUM_REQ = 3;
    localparam int ARB_BURST_W = 4;
    localparam int ARB_MAX_BURST = 12;
endpackage

// File: rtl/ext_bus_arbiter_if.sv
// ext_bus_arbiter_if: request/beat handshake bundle between burst engines, external bus and arbiter
// Signals: req_valid/req_write/req_len/req_hs from requesters, bus_hs_in from the external bus;
//          bus_hs_out/gnt/grant_id/beat_fire/last_beat/bus_drive/busy/err_len from the arbiter.
// Modports: master = requester/bus side, slave = arbiter side.
interface ext_bus_arbiter_if
    import ext_bus_arbiter_pkg::*;
#(
    parameter int NUM_REQ = ARB_NUM_REQ,
    parameter int BURST_W = ARB_BURST_W
);
    localparam int ID_W = $clog2(NUM_REQ);
    logic [NUM_REQ-1:0] req_valid;
    logic [NUM_REQ-1:0] req_write;
    logic [NUM_REQ*BURST_W-1:0] req_len;
    logic [NUM_REQ-1:0] req_hs;
    logic bus_hs_in;
    logic bus_hs_out;
    logic [NUM_REQ-1:0] gnt;
    logic [ID_W-1:0] grant_id;
    logic [NUM_REQ-1:0] beat_fire;
    logic last_beat;
    logic bus_drive;
    logic busy;
    logic err_len;
    modport master (
        output req_valid, req_write, req_len, req_hs, bus_hs_in,
        input bus_hs_out, gnt, grant_id, beat_fire, last_beat, bus_drive, busy, err_len
    );
    modport slave (
        input req_valid, req_write, req_len, req_hs, bus_hs_in,
        output bus_hs_out, gnt, grant_id, beat_fire, last_beat, bus_drive, busy, err_len
    );
endinterface

// File: rtl/ext_bus_arbiter_rr_pick.sv
// ext_bus_arbiter_rr_pick: combinational round-robin pick of the first request at or after ptr
// Ports: req (request vector), ptr (search start index) -> win (one-hot), win_id (index, 0 if none).
module ext_bus_arbiter_rr_pick #(
    parameter int NUM_REQ = 3,
    parameter int ID_W = $clog2(NUM_REQ)
) (
    input logic [NUM_REQ-1:0] req,
    input logic [ID_W-1:0] ptr,
    output logic [NUM_REQ-1:0] win,
    output logic [ID_W-1:0] win_id
);
    logic found;
    int j;
    always_comb begin
        win = '0;
        win_id = '0;
        found = 1'b0;
        j = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            j = int'(ptr) + i;
            j = (j >= NUM_REQ) ? j - NUM_REQ : j;
            if (!found && req[j]) begin
                found = 1'b1;
                win[j] = 1'b1;
                win_id = ID_W'(j);
            end
        end
    end
endmodule

// File: rtl/ext_bus_arbiter.sv
// ext_bus_arbiter: grants whole bursts on the shared external bus to the conv accelerator burst engines
// Ports: clk, arst_n_in (synchronous, active-low reset), bus (ext_bus_arbiter_if.slave):
//        requests/lengths/directions/beat handshakes in; grant, beat pulses, bus direction, status out.
module ext_bus_arbiter
    import ext_bus_arbiter_pkg::*;
#(
    parameter int NUM_REQ = ARB_NUM_REQ,
    parameter int MAX_BURST = ARB_MAX_BURST,
    parameter int BURST_W = ARB_BURST_W,
    parameter int PRIO_EN = 1,
    parameter int PRIO_REQ = REQ_OUTPUT
) (
    input logic clk,
    input logic arst_n_in,
    ext_bus_arbiter_if.slave bus
);
    localparam int ID_W = $clog2(NUM_REQ);
    localparam logic [NUM_REQ-1:0] PRIO_OH = NUM_REQ'(1) << PRIO_REQ;
    localparam logic [ID_W-1:0] PRIO_ID = ID_W'(PRIO_REQ);
    localparam logic [BURST_W-1:0] MAX_LEN = BURST_W'(MAX_BURST);
    arb_state_t state;
    logic [NUM_REQ-1:0] gnt, rr_win, win;
    logic [ID_W-1:0] grant_id, ptr, rr_id, win_id;
    logic [BURST_W-1:0] cnt, win_len, load;
    logic bus_drive, err_len, prio, fire, len_zero, len_big;
    ext_bus_arbiter_rr_pick #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_rr_pick (
        .req(bus.req_valid),
        .ptr(ptr),
        .win(rr_win),
        .win_id(rr_id)
    );
    assign prio = (PRIO_EN != 0) && bus.req_valid[PRIO_REQ];
    assign win = prio ? PRIO_OH : rr_win;
    assign win_id = prio ? PRIO_ID : rr_id;
    assign win_len = bus.req_len[win_id*BURST_W +: BURST_W];
    assign len_zero = win_len == '0;
    assign len_big = win_len > MAX_LEN;
    // Counter holds beats remaining minus one, so a zero-length request still moves one beat.
    assign load = len_zero ? '0 : len_big ? MAX_LEN - 1'b1 : win_len - 1'b1;
    // gnt is zero outside BURST, which gates every combinational output.
    assign fire = |(gnt & bus.req_hs) & bus.bus_hs_in;
    always_ff @(posedge clk) begin
        if (!arst_n_in) begin
            state <= ARB_IDLE;
            gnt <= '0;
            grant_id <= '0;
            ptr <= '0;
            cnt <= '0;
            bus_drive <= 1'b0;
            err_len <= 1'b0;
        end else if (state == ARB_IDLE) begin
            if (|bus.req_valid) begin
                state <= ARB_BURST;
                gnt <= win;
                grant_id <= win_id;
                cnt <= load;
                bus_drive <= |(win & bus.req_write);
                err_len <= err_len | len_zero | len_big;
            end
        end else if (fire) begin
            if (cnt == '0) begin
                state <= ARB_IDLE;
                gnt <= '0;
                grant_id <= '0;
                bus_drive <= 1'b0;
                ptr <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
            end else begin
                cnt <= cnt - 1'b1;
            end
        end
    end
    assign bus.bus_hs_out = |(gnt & bus.req_hs);
    assign bus.gnt = gnt;
    assign bus.grant_id = grant_id;
    assign bus.beat_fire = gnt & {NUM_REQ{fire}};
    assign bus.last_beat = fire && cnt == '0;
    assign bus.bus_drive = bus_drive;
    assign bus.busy = state == ARB_BURST;
    assign bus.err_len = err_len;
endmodule

// File: tb/tb_ext_bus_arbiter.sv
// tb_ext_bus_arbiter: table-driven, scoreboarded bench for ext_bus_arbiter
// Ports: none (drives an ext_bus_arbiter_if instance and the DUT clock/reset).
module tb_ext_bus_arbiter;
    import ext_bus_arbiter_pkg::*;
    typedef struct {
        int t;
        logic rst_n;
        logic [2:0] rv, rw, hs;
        logic [11:0] len;
        logic bin;
        logic [2:0] gnt, bf;
        logic lb, bd, busy, err;
    } vec_t;
    logic clk = 1'b0;
    logic rst_n;
    vec_t tbl[$];
    vec_t sb[$];
    int n_run = 0;
    int n_fail = 0;
    ext_bus_arbiter_if #(.NUM_REQ(3), .BURST_W(4)) bus ();
    ext_bus_arbiter #(
        .NUM_REQ(3), .MAX_BURST(12), .BURST_W(4), .PRIO_EN(1), .PRIO_REQ(REQ_OUTPUT)
    ) dut (
        .clk(clk),
        .arst_n_in(rst_n),
        .bus(bus)
    );
    always #5 clk = ~clk;
    function automatic vec_t v(input int t, input logic rst_n_i, input logic [2:0] rv,
                               input logic [2:0] rw, input logic [11:0] len, input logic [2:0] hs,
                               input logic bin, input logic [2:0] gnt, input logic [2:0] bf,
                               input logic lb, input logic bd, input logic busy, input logic err);
        vec_t x;
        x.t = t; x.rst_n = rst_n_i; x.rv = rv; x.rw = rw; x.len = len; x.hs = hs; x.bin = bin;
        x.gnt = gnt; x.bf = bf; x.lb = lb; x.bd = bd; x.busy = busy; x.err = err;
        return x;
    endfunction
    function automatic logic [1:0] oh2id(input logic [2:0] g);
        return g[1] ? 2'd1 : g[2] ? 2'd2 : 2'd0;
    endfunction
    task automatic chk(input int t, input int r, input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL t%0d row %0d %s: got %0h want %0h", t, r, nm, act, exp);
        end
    endtask
    task automatic apply(input vec_t x, input int r);
        vec_t e;
        @(negedge clk);
        rst_n = x.rst_n;
        bus.req_valid = x.rv;
        bus.req_write = x.rw;
        bus.req_len = x.len;
        bus.req_hs = x.hs;
        bus.bus_hs_in = x.bin;
        sb.push_back(x);
        #2;
        e = sb.pop_front();
        chk(e.t, r, "gnt", 32'(bus.gnt), 32'(e.gnt));
        chk(e.t, r, "grant_id", 32'(bus.grant_id), 32'(oh2id(e.gnt)));
        chk(e.t, r, "beat_fire", 32'(bus.beat_fire), 32'(e.bf));
        chk(e.t, r, "last_beat", 32'(bus.last_beat), 32'(e.lb));
        chk(e.t, r, "bus_drive", 32'(bus.bus_drive), 32'(e.bd));
        chk(e.t, r, "busy", 32'(bus.busy), 32'(e.busy));
        chk(e.t, r, "err_len", 32'(bus.err_len), 32'(e.err));
        chk(e.t, r, "bus_hs_out", 32'(bus.bus_hs_out), 32'(|(e.gnt & e.hs)));
    endtask
    initial begin
        logic [11:0] l;
        rst_n = 1'b0;
        bus.req_valid = '0;
        bus.req_write = '0;
        bus.req_len = '0;
        bus.req_hs = '0;
        bus.bus_hs_in = 1'b0;
        repeat (2) @(posedge clk);
        tbl.push_back(v(0, 0, 3'b000, 3'b000, 12'h000, 3'b111, 1, 3'b000, 3'b000, 0, 0, 0, 0));
        // single 3-beat burst for requester 1
        l = {4'd0, 4'd3, 4'd0};
        tbl.push_back(v(1, 1, 3'b010, 3'b000, l, 3'b111, 1, 3'b000, 3'b000, 0, 0, 0, 0));
        tbl.push_back(v(1, 1, 3'b000, 3'b000, l, 3'b111, 1, 3'b010, 3'b010, 0, 0, 1, 0));
        tbl.push_back(v(1, 1, 3'b000, 3'b000, l, 3'b111, 1, 3'b010, 3'b010, 0, 0, 1, 0));
        tbl.push_back(v(1, 1, 3'b000, 3'b000, l, 3'b111, 1, 3'b010, 3'b010, 1, 0, 1, 0));
        tbl.push_back(v(1, 1, 3'b000, 3'b000, l, 3'b111, 1, 3'b000, 3'b000, 0, 0, 0, 0));
        // round-robin between 0 and 1, pointer starts at 2 and wraps
        l = {4'd2, 4'd2, 4'd2};
        tbl.push_back(v(2, 1, 3'b011, 3'b000, l, 3'b111, 1, 3'b000, 3'b000, 0, 0, 0, 0));
        tbl.push_back(v(2, 1, 3'b011, 3'b000, l, 3'b111, 1, 3'b001, 3'b001, 0, 0, 1, 0));
        tbl.push_back(v(2, 1, 3'b011, 3'b000, l, 3'b111, 1, 3'b001, 3'b001, 1, 0, 1, 0));
        tbl.push_back(v(2, 1, 3'b011, 3'b000, l, 3'b111, 1, 3'b000, 3'b000, 0, 0, 0, 0));
        tbl.push_back(v(2, 1, 3'b011, 3'b000, l, 3'b111, 1, 3'b010, 3'b010, 0, 0, 1, 0));
        tbl.push_back(v(2, 1, 3'b011, 3'b000, l, 3'b111, 1, 3'b010, 3'b010, 1, 0, 1, 0));
        tbl.push_back(v(2, 1, 3'b011, 3'b000, l, 3'b111, 1, 3'b000, 3'b000, 0, 0, 0, 0));
        tbl.push_back(v(2, 1, 3'b000, 3'b000, l, 3'b111, 1, 3'b001, 3'b001, 0, 0, 1, 0));
        tbl.push_back(v(2, 1, 3'b000, 3'b000, l, 3'b111, 1, 3'b001, 3'b001, 1, 0, 1, 0));
        tbl.push_back(v(2, 1, 3'b000, 3'b000, l, 3'b111, 1, 3'b000, 3'b000, 0, 0, 0, 0));
        // priority writeback first with bus_drive, then round-robin 0 then 1
        l = {4'd1, 4'd1, 4'd1};
        tbl.push_back(v(3, 1, 3'b111, 3'b100, l, 3'b111, 1, 3'b000, 3'b000, 0, 0, 0, 0));
        tbl.push_back(v(3, 1, 3'b011, 3'b100, l, 3'b111, 1, 3'b100, 3'b100, 1, 1, 1, 0));
        tbl.push_back(v(3, 1, 3'b011, 3'b100, l, 3'b111, 1, 3'b000, 3'b000, 0, 0, 0, 0));
        tbl.push_back(v(3, 1, 3'b010, 3'b100, l, 3'b111, 1, 3'b001, 3'b001, 1, 0, 1, 0));
        tbl.push_back(v(3, 1, 3'b010, 3'b100, l, 3'b111, 1, 3'b000, 3'b000, 0, 0, 0, 0));
        tbl.push_back(v(3, 1, 3'b000, 3'b100, l, 3'b111, 1, 3'b010, 3'b010, 1, 0, 1, 0));
        tbl.push_back(v(3, 1, 3'b000, 3'b000, l, 3'b111, 1, 3'b000, 3'b000, 0, 0, 0, 0));
        foreach (tbl[i]) apply(tbl[i], i);
        // 4-beat burst with bus-side and requester-side stalls
        l = {4'd0, 4'd0, 4'd4};
        apply(v(4, 1, 3'b001, 3'b000, l, 3'b111, 1, 3'b000, 3'b000, 0, 0, 0, 0), 0);
        apply(v(4, 1, 3'b000, 3'b000, l, 3'b111, 1, 3'b001, 3'b001, 0, 0, 1, 0), 1);
        apply(v(4, 1, 3'b000, 3'b000, l, 3'b111, 0, 3'b001, 3'b000, 0, 0, 1, 0), 2);
        apply(v(4, 1, 3'b000, 3'b000, l, 3'b111, 1, 3'b001, 3'b001, 0, 0, 1, 0), 3);
        apply(v(4, 1, 3'b000, 3'b000, l, 3'b110, 1, 3'b001, 3'b000, 0, 0, 1, 0), 4);
        apply(v(4, 1, 3'b000, 3'b000, l, 3'b111, 1, 3'b001, 3'b001, 0, 0, 1, 0), 5);
        apply(v(4, 1, 3'b000, 3'b000, l, 3'b111, 0, 3'b001, 3'b000, 0, 0, 1, 0), 6);
        apply(v(4, 1, 3'b000, 3'b000, l, 3'b111, 1, 3'b001, 3'b001, 1, 0, 1, 0), 7);
        apply(v(4, 1, 3'b000, 3'b000, l, 3'b111, 1, 3'b000, 3'b000, 0, 0, 0, 0), 8);
        // zero length runs one beat, oversize clamps to 12; err_len is sticky
        apply(v(5, 1, 3'b001, 3'b000, 12'h000, 3'b111, 1, 3'b000, 3'b000, 0, 0, 0, 0), 0);
        apply(v(5, 1, 3'b000, 3'b000, 12'h000, 3'b111, 1, 3'b001, 3'b001, 1, 0, 1, 1), 1);
        apply(v(5, 1, 3'b001, 3'b000, 12'h00f, 3'b111, 1, 3'b000, 3'b000, 0, 0, 0, 1), 2);
        for (int i = 0; i < 12; i++)
            apply(v(5, 1, 3'b000, 3'b000, 12'h00f, 3'b111, 1, 3'b001, 3'b001, i == 11, 0, 1, 1), 3 + i);
        apply(v(5, 1, 3'b000, 3'b000, 12'h00f, 3'b111, 1, 3'b000, 3'b000, 0, 0, 0, 1), 15);
        // reset on beat 2 of a 5-beat burst; pointer returns to 0
        l = {4'd0, 4'd5, 4'd0};
        apply(v(6, 1, 3'b010, 3'b000, l, 3'b111, 1, 3'b000, 3'b000, 0, 0, 0, 1), 0);
        apply(v(6, 1, 3'b000, 3'b000, l, 3'b111, 1, 3'b010, 3'b010, 0, 0, 1, 1), 1);
        apply(v(6, 0, 3'b000, 3'b000, l, 3'b111, 1, 3'b010, 3'b010, 0, 0, 1, 1), 2);
        apply(v(6, 1, 3'b011, 3'b000, 12'h011, 3'b111, 1, 3'b000, 3'b000, 0, 0, 0, 0), 3);
        apply(v(6, 1, 3'b000, 3'b000, 12'h011, 3'b111, 1, 3'b001, 3'b001, 1, 0, 1, 0), 4);
        apply(v(6, 1, 3'b000, 3'b000, 12'h011, 3'b111, 1, 3'b000, 3'b000, 0, 0, 0, 0), 5);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
